// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier and the ALU that drives it.
package mult_pkg;

  localparam int MULT_WIDTH = 16;

  typedef enum logic {
    OCIOSO = 1'b0,
    CALC   = 1'b1
  } state_t;

endpackage

// File: rtl/multiplicador_seq.sv
// Sequential shift-add unsigned multiplier started by the ALU's ini strobe.
// state  | meaning
// OCIOSO | idle, waiting for a rising edge on ini
// CALC   | WIDTH add/shift steps in progress
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ini,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  output logic [WIDTH-1:0] res_low,
  output logic [WIDTH-1:0] res_high,
  output logic             ocupado,
  output logic             pronto
);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ini_ant_q;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [2*WIDTH:0]       p_q, p_d;
  logic [2*WIDTH-1:0]     res_q, res_d;
  logic                   pronto_q, pronto_d;

  logic                   inicio;
  logic                   ultimo;
  logic [WIDTH:0]         p_hi_sum;
  logic [2*WIDTH:0]       p_step;

  assign inicio = ini & ~ini_ant_q;
  assign ultimo = (cnt_q == CNT_W'(WIDTH - 1));

  // Upper part is WIDTH+1 bits so the adder carry survives until the shift.
  always_comb begin
    p_hi_sum = p_q[2*WIDTH:WIDTH];
    if (p_q[0]) begin
      p_hi_sum = p_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    end
    p_step = {p_hi_sum, p_q[WIDTH-1:0]} >> 1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      cnt_q     <= '0;
      ini_ant_q <= 1'b0;
      mcand_q   <= '0;
      p_q       <= '0;
      res_q     <= '0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ini_ant_q <= ini;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      res_q     <= res_d;
      pronto_q  <= pronto_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    p_d      = p_q;
    res_d    = res_q;
    pronto_d = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (inicio) begin
          mcand_d = operando1;
          p_d     = {{(WIDTH + 1){1'b0}}, operando2};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        p_d   = p_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (ultimo) begin
          res_d    = p_step[2*WIDTH-1:0];
          pronto_d = 1'b1;
          state_d  = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado  = (state_q == CALC);
    pronto   = pronto_q;
    res_low  = res_q[WIDTH-1:0];
    res_high = res_q[2*WIDTH-1:WIDTH];
  end

endmodule

// File: doc/multiplicador_seq.md
Name: multiplicador_seq

Overview:
- Sequential shift-add multiplier.
- Acts as the responder to the ALU's `ini` start strobe: it latches the two register operands and computes the unsigned double-width product.
- Publishes the product on `res_low`/`res_high`; the ALU reads these back via its move-low and move-high opcodes.
- Fixed latency of WIDTH cycles per product; one multiplication in flight at a time.

Parameters:
- WIDTH, 16, operand width; the product is 2*WIDTH bits.
- CNT_W, 5, step-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ini  input  1  start request from the ALU, level signal; a start is its 0->1 transition.
- operando1  input  WIDTH  multiplicand, sampled on the start edge.
- operando2  input  WIDTH  multiplier, sampled on the start edge.
- res_low  output  WIDTH  product bits [WIDTH-1:0], registered.
- res_high  output  WIDTH  product bits [2*WIDTH-1:WIDTH], registered.
- ocupado  output  1  high while a multiplication is in progress.
- pronto  output  1  one-cycle pulse: new res_low/res_high valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=OCIOSO; res_low=0, res_high=0, ocupado=0, pronto=0.
  - Step counter=0, ini_ant (previous ini)=0, internal product/multiplicand registers=0.
- Start detection: inicio = ini & ~ini_ant; ini_ant <= ini on every edge.
  - ini held high for many cycles produces exactly one start.
  - ini high when reset releases counts as a start at the first edge.
- States: OCIOSO, CALC.
- OCIOSO + inicio at edge k:
  - mcand <= operando1; P <= {WIDTH+1 zeros, operando2}.
  - cnt <= 0; state <= CALC; ocupado=1 from edge k.
- CALC, each edge (steps 1..WIDTH):
  - If P[0]=1, upper part (WIDTH+1 bits) = P_high + mcand, keeping the carry; otherwise unchanged.
  - Then shift the whole P right by 1; cnt <= cnt+1.
- Completion, at the edge where cnt==WIDTH-1 (edge k+WIDTH):
  - Final step performed.
  - {res_high,res_low} <= resulting 2*WIDTH product.
  - pronto <= 1 for exactly one cycle; ocupado <= 0; state <= OCIOSO.
- Latency: start edge k -> results and pronto visible after edge k+WIDTH (16 cycles at default).
- inicio while in CALC: ignored; no restart; operands not resampled.
- inicio in the same cycle that pronto is high: accepted, since state is OCIOSO; it starts a new product.
- res_low/res_high hold the last completed product until the next completion.
  - They are not cleared on a new start.
  - Only reset clears them.
- Arithmetic: unsigned only.
  - Maximum 0xFFFF*0xFFFF = 0xFFFE0001 at WIDTH=16; no overflow is possible.
  - The carry bit of the adder is mandatory.
- Reset mid-CALC: computation abandoned; outputs return to their reset values; no pronto.
- Operand changes after the start edge have no effect on the running product.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum (OCIOSO=1'b0, CALC=1'b1);
  - the WIDTH default constant (16), shared with the ALU's res_low/res_high width.
- No sub-module needed.
  - Start-edge detection and the datapath stay inline.
  - The datapath is a single (WIDTH+1)-bit adder plus shift register.

Test Plan:
- Basic product: operando1=3, operando2=5, ini 0->1 -> after 16 edges, pronto pulses one cycle with res_low=0x000F, res_high=0x0000; ocupado high for exactly 16 cycles.
- Maximum operands: 0xFFFF x 0xFFFF -> res_high=0xFFFE, res_low=0x0001; 0x1234 x 0x0100 -> res_high=0x0012, res_low=0x3400.
- Held ini: ini held high 50 cycles with 7 x 9 -> exactly one pronto, res_low=0x003F; no second start until ini returns to 0 and rises again.
- Start during CALC: ini toggled at cycle 5 of a 10 x 10 product, with operands changed to 2 x 2 -> result 0x0064, one pronto; the new operands are ignored.
- Reset mid-CALC: reset=0 at step 8 of 0x00FF x 0x00FF -> outputs 0 immediately (asynchronous), no pronto; a fresh start after release gives 0xFE01.
- Back-to-back: new ini edge in the pronto cycle with 0 x 0x1234 -> second pronto 16 cycles later; res_low/res_high keep the first product until then, then both become 0.
